cpu_seq_ctrl: RTL and testbench

- Multi-cycle control sequencer for the 16-bit CPU core. Steps the shared datapath through instruction fetch, decode, execute, optional multiply-wait and memory access, and writeback.
- Consumes the per-instruction control flags produced by the instruction decoder. Drives enables for the instruction-memory and data-memory handshakes, the iterative multiplier, the register file, the CSR file and the PC.
- Detects memory-bus timeouts and counts retired instructions.

---
 rtl/cpu_seq_ctrl_if.sv | 48 ++++
 rtl/cpu_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - sequencer <-> datapath control bundle
interface cpu_seq_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             halt;
  logic             imem_ack;
  logic             dmem_ack;
  logic             mul_done;
  logic             cmp_true;
  logic             dec_mul;
  logic             dec_load;
  logic             dec_store;
  logic             dec_branch;
  logic             dec_jump;
  logic             dec_reg_we;
  logic             dec_csr_wr;
  logic             dec_reg_clear;

  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             mul_start;
  logic             reg_we;
  logic             csr_we;
  logic             rf_clear;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  halt, imem_ack, dmem_ack, mul_done, cmp_true,
           dec_mul, dec_load, dec_store, dec_branch, dec_jump,
           dec_reg_we, dec_csr_wr, dec_reg_clear,
    output imem_req, ir_we, dmem_req, dmem_we, mul_start,
           reg_we, csr_we, rf_clear, pc_we, pc_sel, bus_err, state, instret
  );

  modport slave (
    output halt, imem_ack, dmem_ack, mul_done, cmp_true,
           dec_mul, dec_load, dec_store, dec_branch, dec_jump,
           dec_reg_we, dec_csr_wr, dec_reg_clear,
    input  imem_req, ir_we, dmem_req, dmem_we, mul_start,
           reg_we, csr_we, rf_clear, pc_we, pc_sel, bus_err, state, instret
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer
module cpu_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MULW   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q;
  logic             take_branch_q;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             dmem_we_q;
  logic             mul_start_q;
  logic             reg_we_q;
  logic             csr_we_q;
  logic             rf_clear_q;
  logic             pc_we_q;
  logic [1:0]       pc_sel_q;
  logic             bus_err_q;
  logic [CNT_W-1:0] instret_q;

  logic wait_expired;
  logic to_wb;
  logic take_now;
  logic entering_wait;
  logic waiting;

  // Last allowed wait cycle: an ack here still wins, silence here is an error.
  assign wait_expired  = (wait_cnt_q == WAIT_LAST);
  assign to_wb         = (state_d == S_WB);
  assign take_now      = (state_q == S_EXEC) ? bus.cmp_true : take_branch_q;
  assign entering_wait = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
  assign waiting       = ((state_q == S_FETCH) && !bus.imem_ack) ||
                         ((state_q == S_MEM) && !bus.dmem_ack);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.halt && !bus_err_q) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)      state_d = S_DECODE;
        else if (wait_expired) state_d = S_ERR;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.dec_mul)                         state_d = S_MULW;
        else if (bus.dec_load || bus.dec_store)  state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MULW:   if (bus.mul_done) state_d = S_WB;
      S_MEM: begin
        if (bus.dmem_ack)      state_d = S_WB;
        else if (wait_expired) state_d = S_ERR;
      end
      S_WB:     state_d = bus.halt ? S_IDLE : S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 8'd0;
      take_branch_q <= 1'b0;
      imem_req_q    <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      mul_start_q   <= 1'b0;
      reg_we_q      <= 1'b0;
      csr_we_q      <= 1'b0;
      rf_clear_q    <= 1'b0;
      pc_we_q       <= 1'b0;
      pc_sel_q      <= 2'd0;
      bus_err_q     <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q <= state_d;

      if (entering_wait)  wait_cnt_q <= 8'd0;
      else if (waiting)   wait_cnt_q <= wait_cnt_q + 8'd1;

      if (state_q == S_EXEC) take_branch_q <= bus.cmp_true;

      imem_req_q  <= (state_d == S_FETCH);
      mul_start_q <= (state_d == S_EXEC) && bus.dec_mul;
      dmem_req_q  <= (state_d == S_MEM);
      dmem_we_q   <= (state_d == S_MEM) && bus.dec_store;

      reg_we_q    <= to_wb && bus.dec_reg_we;
      csr_we_q    <= to_wb && bus.dec_csr_wr;
      rf_clear_q  <= to_wb && bus.dec_reg_clear;
      pc_we_q     <= to_wb;
      pc_sel_q    <= !to_wb                       ? 2'd0 :
                     bus.dec_jump                 ? 2'd2 :
                     (bus.dec_branch && take_now) ? 2'd1 : 2'd0;

      if (state_q == S_WB) instret_q <= instret_q + CNT_W'(1);

      if ((state_d == S_ERR) && (state_q != S_ERR)) bus_err_q <= 1'b1;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.ir_we     = imem_req_q && bus.imem_ack;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.mul_start = mul_start_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.csr_we    = csr_we_q;
  assign bus.rf_clear  = rf_clear_q;
  assign bus.pc_we     = pc_we_q;
  assign bus.pc_sel    = pc_sel_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - directed bench: per-instruction expected cycle traces vs DUT
module tb_cpu_seq_ctrl;
  localparam int TO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if #(.CNT_W(CW)) bus ();
  cpu_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // strb order: imem_req ir_we dmem_req dmem_we mul_start reg_we csr_we rf_clear pc_we
  typedef struct {
    bit          chk;
    bit          rst, halt, imem_ack, dmem_ack, mul_done, cmp_true;
    bit          mul, load, store, branch, jump, reg_we, csr_wr, reg_clear;
    bit [2:0]    st;
    bit [8:0]    strb;
    bit [1:0]    pc_sel;
    bit          bus_err;
    bit [CW-1:0] instret;
  } cyc_t;

  typedef struct {
    int fw;
    int xw;
    bit mul, load, store, branch, jump, reg_we, csr_wr, reg_clear, cmp;
    bit done_early, halt_mid, halt_after, rst_mulw;
  } ins_t;

  cyc_t        q[$];
  int unsigned mdl_cnt = 0;
  bit          mdl_err = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic cyc_t base(input bit [2:0] st);
    cyc_t c;
    c = '{default: 0};
    c.chk     = 1'b1;
    c.st      = st;
    c.bus_err = mdl_err;
    c.instret = mdl_cnt[CW-1:0];
    return c;
  endfunction

  function automatic cyc_t with_dec(input cyc_t c0, input ins_t d);
    cyc_t c;
    c = c0;
    c.mul = d.mul; c.load = d.load; c.store = d.store; c.branch = d.branch;
    c.jump = d.jump; c.reg_we = d.reg_we; c.csr_wr = d.csr_wr; c.reg_clear = d.reg_clear;
    c.cmp_true = !d.cmp;
    c.halt = d.halt_mid;
    return c;
  endfunction

  task automatic idle(input int n, input bit halt);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base(3'd0);
      c.halt = halt;
      q.push_back(c);
    end
  endtask

  task automatic err_cycles(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base(3'd7);
      c.imem_ack = 1'b1; c.dmem_ack = 1'b1; c.mul_done = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic reset_cycle(input bit [2:0] st, input bit chk);
    cyc_t c;
    c = base(st);
    c.rst = 1'b1;
    c.chk = chk;
    q.push_back(c);
    mdl_cnt = 0;
    mdl_err = 1'b0;
  endtask

  // Expected trace of one instruction, from its first FETCH cycle to its WB cycle.
  task automatic gen_instr(input ins_t d);
    cyc_t c;
    int   n;
    n = (d.fw >= TO) ? TO : d.fw + 1;
    for (int i = 0; i < n; i++) begin
      c = base(3'd1);
      c.cmp_true = !d.cmp;
      c.imem_ack = (d.fw < TO) && (i == d.fw);
      c.strb = {1'b1, c.imem_ack, 7'b0};
      q.push_back(c);
    end
    if (d.fw >= TO) begin
      mdl_err = 1'b1;
      return;
    end
    q.push_back(with_dec(base(3'd2), d));
    c = with_dec(base(3'd3), d);
    c.cmp_true = d.cmp;
    c.mul_done = d.done_early;
    c.strb = {4'b0, d.mul, 4'b0};
    q.push_back(c);
    if (d.mul) begin
      for (int j = 1; j <= d.xw; j++) begin
        c = with_dec(base(3'd4), d);
        c.mul_done = (j == d.xw);
        c.rst = d.rst_mulw && (j == 1);
        q.push_back(c);
        if (c.rst) begin
          mdl_cnt = 0;
          mdl_err = 1'b0;
          return;
        end
      end
    end else if (d.load || d.store) begin
      n = (d.xw >= TO) ? TO : d.xw + 1;
      for (int i = 0; i < n; i++) begin
        c = with_dec(base(3'd5), d);
        c.dmem_ack = (d.xw < TO) && (i == d.xw);
        c.strb = {2'b0, 1'b1, d.store, 5'b0};
        q.push_back(c);
      end
      if (d.xw >= TO) begin
        mdl_err = 1'b1;
        return;
      end
    end
    c = with_dec(base(3'd6), d);
    c.halt = d.halt_after;
    c.strb = {5'b0, d.reg_we, d.csr_wr, d.reg_clear, 1'b1};
    c.pc_sel = d.jump ? 2'd2 : (d.branch && d.cmp) ? 2'd1 : 2'd0;
    q.push_back(c);
    mdl_cnt++;
  endtask

  function automatic int count_st(input int from, input bit [2:0] st);
    int n = 0;
    for (int k = from; k < q.size(); k++) if (q[k].st == st) n++;
    return n;
  endfunction

  function automatic int count_strb(input int from, input int bitn);
    int n = 0;
    for (int k = from; k < q.size(); k++) if (q[k].strb[bitn]) n++;
    return n;
  endfunction

  task automatic build();
    ins_t d;
    int   s0;
    reset_cycle(3'd0, 1'b0);
    reset_cycle(3'd0, 1'b0);
    idle(2, 1'b1);
    idle(1, 1'b0);
    s0 = q.size();
    d = '{reg_we: 1, default: 0};
    gen_instr(d);
    check("pin_add_len", 64'(q.size() - s0), 64'd4);
    check("pin_add_wb", {q[q.size()-1].strb, q[q.size()-1].pc_sel}, {9'b000001001, 2'd0});
    s0 = q.size();
    d = '{fw: 1, xw: 3, mul: 1, reg_we: 1, done_early: 1, default: 0};
    gen_instr(d);
    check("pin_mul_mulw", 64'(count_st(s0, 3'd4)), 64'd3);
    check("pin_mul_start", 64'(count_strb(s0, 4)), 64'd1);
    s0 = q.size();
    d = '{xw: 2, store: 1, default: 0};
    gen_instr(d);
    check("pin_st_req", 64'(count_strb(s0, 6)), 64'd3);
    check("pin_st_we", 64'(count_strb(s0, 5)), 64'd3);
    check("pin_st_regwe", 64'(count_strb(s0, 3)), 64'd0);
    d = '{fw: 2, xw: 0, load: 1, reg_we: 1, default: 0};
    gen_instr(d);
    d = '{branch: 1, cmp: 1, default: 0};
    gen_instr(d);
    check("pin_br_taken", 64'(q[q.size()-1].pc_sel), 64'd1);
    d = '{branch: 1, cmp: 0, default: 0};
    gen_instr(d);
    d = '{jump: 1, branch: 1, cmp: 1, csr_wr: 1, default: 0};
    gen_instr(d);
    check("pin_jump", 64'(q[q.size()-1].pc_sel), 64'd2);
    d = '{xw: 1, load: 1, branch: 1, cmp: 1, reg_clear: 1, default: 0};
    gen_instr(d);
    d = '{xw: 1, load: 1, reg_we: 1, halt_mid: 1, halt_after: 1, default: 0};
    gen_instr(d);
    idle(3, 1'b1);
    idle(1, 1'b0);
    d = '{fw: TO - 1, reg_we: 1, default: 0};
    gen_instr(d);
    d = '{xw: 3, mul: 1, reg_we: 1, rst_mulw: 1, default: 0};
    gen_instr(d);
    q[q.size()-1].mul_done = 1'b0;
    idle(1, 1'b1);
    q[q.size()-1].mul_done = 1'b1;
    idle(1, 1'b1);
    idle(1, 1'b0);
    d = '{fw: TO, default: 0};
    gen_instr(d);
    err_cycles(3);
    reset_cycle(3'd7, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    d = '{fw: 2, xw: TO, store: 1, default: 0};
    gen_instr(d);
    err_cycles(2);
    reset_cycle(3'd7, 1'b1);
    idle(1, 1'b0);
    d = '{reg_we: 1, halt_after: 1, default: 0};
    gen_instr(d);
    idle(3, 1'b1);
  endtask

  task automatic drive(input cyc_t c);
    rst               = c.rst;
    bus.halt          = c.halt;
    bus.imem_ack      = c.imem_ack;
    bus.dmem_ack      = c.dmem_ack;
    bus.mul_done      = c.mul_done;
    bus.cmp_true      = c.cmp_true;
    bus.dec_mul       = c.mul;
    bus.dec_load      = c.load;
    bus.dec_store     = c.store;
    bus.dec_branch    = c.branch;
    bus.dec_jump      = c.jump;
    bus.dec_reg_we    = c.reg_we;
    bus.dec_csr_wr    = c.csr_wr;
    bus.dec_reg_clear = c.reg_clear;
  endtask

  initial begin
    logic [8:0] act_strb;
    build();
    foreach (q[k]) begin
      @(negedge clk);
      drive(q[k]);
      #1;
      if (q[k].chk) begin
        act_strb = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.mul_start,
                    bus.reg_we, bus.csr_we, bus.rf_clear, bus.pc_we};
        check($sformatf("cyc%0d st/strb/pcsel/err/instret", k),
              64'({bus.state, act_strb, bus.pc_sel, bus.bus_err, bus.instret}),
              64'({q[k].st, q[k].strb, q[k].pc_sel, q[k].bus_err, q[k].instret}));
      end
    end
    @(negedge clk);
    #1;
    check("final_instret", 64'(bus.instret), 64'd1);
    check("final_state", 64'(bus.state), 64'd0);
    check("final_bus_err", 64'(bus.bus_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
